cpu_addr_seq: RTL

- Parametrised address-sequencing unit for the 6502-style core: takes over operand fetch and effective-address generation from the CPU state machine.
- Covers absolute, indexed, zero-page, indirect-JMP, relative-branch and stack push/pull modes.
- Adds correct page-crossing fix-up cycles, which the first-generation core lacks.
- Sits between the core's control unit (start/mode/index) and the memory address bus; the core keeps instruction decode and the ALU.

---
 rtl/cpu_addr_seq_if.sv | 39 +++
 rtl/cpu_addr_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_addr_seq_if.sv
// =============================================================================
// Module : cpu_addr_seq_if
// Desc   : Control/memory-side signal bundle of the address sequencer.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

interface cpu_addr_seq_if #(
  parameter int DATA_W = 8
);
  logic                  start;
  logic [2:0]            mode;
  logic [DATA_W-1:0]     index;
  logic [2*DATA_W-1:0]   pc_in;
  logic [DATA_W-1:0]     sp_in;
  logic [DATA_W-1:0]     data_in;
  logic                  branch_take;
  logic [2*DATA_W-1:0]   adr_out;
  logic                  mem_wr;
  logic [2*DATA_W-1:0]   pc_out;
  logic                  pc_load;
  logic [DATA_W-1:0]     sp_out;
  logic                  sp_load;
  logic                  busy;
  logic                  done;
  logic                  page_cross;

  modport master (
    output start, mode, index, pc_in, sp_in, data_in, branch_take,
    input  adr_out, mem_wr, pc_out, pc_load, sp_out, sp_load, busy, done, page_cross
  );

  modport slave (
    input  start, mode, index, pc_in, sp_in, data_in, branch_take,
    output adr_out, mem_wr, pc_out, pc_load, sp_out, sp_load, busy, done, page_cross
  );
endinterface

`default_nettype wire

// File: rtl/cpu_addr_seq.sv
// =============================================================================
// Module : cpu_addr_seq
// Desc   : 6502-style operand fetch / effective-address sequencer (falling edge).
// Macro  : CPU_ADDR_PAGE_FIX_EN enables the ABS_IDX page-crossing fix-up cycle.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module cpu_addr_seq #(
  parameter int                  DATA_W    = 8,
  parameter logic [DATA_W-1:0]   STACK_HI  = 'h01,
  parameter logic [2*DATA_W-1:0] RESET_VEC = 'h8000
) (
  input  logic          clk,
  input  logic          n_reset,
  cpu_addr_seq_if.slave bus
);

  localparam int                c_AW     = 2 * DATA_W;
  localparam logic [c_AW-1:0]   c_ONE_A  = {{(c_AW-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] c_ONE_D  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] c_ZERO_D = '0;

  localparam logic [2:0] c_M_ABS     = 3'd0;
  localparam logic [2:0] c_M_ABS_IDX = 3'd1;
  localparam logic [2:0] c_M_ZP      = 3'd2;
  localparam logic [2:0] c_M_ZP_IDX  = 3'd3;
  localparam logic [2:0] c_M_IND     = 3'd4;
  localparam logic [2:0] c_M_REL     = 3'd5;
  localparam logic [2:0] c_M_PUSH    = 3'd6;
  localparam logic [2:0] c_M_PULL    = 3'd7;

  localparam logic [3:0] c_S_IDLE   = 4'd0;
  localparam logic [3:0] c_S_OPLO   = 4'd1;
  localparam logic [3:0] c_S_OPHI   = 4'd2;
  localparam logic [3:0] c_S_FIX    = 4'd3;
  localparam logic [3:0] c_S_IND_LO = 4'd4;
  localparam logic [3:0] c_S_IND_HI = 4'd5;
  localparam logic [3:0] c_S_BR     = 4'd6;
  localparam logic [3:0] c_S_BRFIX  = 4'd7;
  localparam logic [3:0] c_S_STK    = 4'd8;

  logic [3:0]        r_state, w_state;
  logic [2:0]        r_mode, w_mode;
  logic [DATA_W-1:0] r_idx, w_idx, r_sp, w_sp, r_lo, w_lo, r_hi, w_hi;
  logic [DATA_W-1:0] r_lo2, w_lo2, r_sp_out, w_sp_out;
  logic [c_AW-1:0]   r_pc, w_pc, r_tgt, w_tgt, r_adr, w_adr, r_pc_out, w_pc_out;
  logic              r_busy, w_busy, r_done, w_done, r_pc_load, w_pc_load;
  logic              r_sp_load, w_sp_load, r_mem_wr, w_mem_wr, r_page_cross, w_page_cross;

  logic [DATA_W-1:0] w_idx_lo;
  logic [c_AW-1:0]   w_pc_inc, w_br_tgt;
  logic              w_fix;
  logic              w_same_page;

`ifdef CPU_ADDR_PAGE_FIX_EN
  logic              r_carry, w_carry;
  logic [DATA_W:0]   w_idx_sum;
  assign w_idx_sum = {1'b0, bus.data_in} + {1'b0, r_idx};
  assign w_idx_lo  = w_idx_sum[DATA_W-1:0];
  assign w_fix     = r_carry;
`else
  assign w_idx_lo  = bus.data_in + r_idx;
  assign w_fix     = 1'b0;
`endif

  assign w_pc_inc    = r_pc + c_ONE_A;
  assign w_br_tgt    = w_pc_inc + {{DATA_W{bus.data_in[DATA_W-1]}}, bus.data_in};
  // r_pc already points past the offset byte once the branch reaches BR
  assign w_same_page = (r_tgt[c_AW-1:DATA_W] == r_pc[c_AW-1:DATA_W]);

  always_ff @(negedge clk) begin
    if (!n_reset) begin
      r_state      <= c_S_IDLE;
      r_mode       <= '0;
      r_idx        <= '0;
      r_sp         <= '0;
      r_lo         <= '0;
      r_hi         <= '0;
      r_lo2        <= '0;
      r_pc         <= '0;
      r_tgt        <= '0;
      r_adr        <= RESET_VEC;
      r_pc_out     <= RESET_VEC;
      r_sp_out     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pc_load    <= 1'b0;
      r_sp_load    <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_page_cross <= 1'b0;
`ifdef CPU_ADDR_PAGE_FIX_EN
      r_carry      <= 1'b0;
`endif
    end else begin
      r_state      <= w_state;
      r_mode       <= w_mode;
      r_idx        <= w_idx;
      r_sp         <= w_sp;
      r_lo         <= w_lo;
      r_hi         <= w_hi;
      r_lo2        <= w_lo2;
      r_pc         <= w_pc;
      r_tgt        <= w_tgt;
      r_adr        <= w_adr;
      r_pc_out     <= w_pc_out;
      r_sp_out     <= w_sp_out;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_pc_load    <= w_pc_load;
      r_sp_load    <= w_sp_load;
      r_mem_wr     <= w_mem_wr;
      r_page_cross <= w_page_cross;
`ifdef CPU_ADDR_PAGE_FIX_EN
      r_carry      <= w_carry;
`endif
    end
  end

  always_comb begin
    w_state = r_state;
    case (r_state)
      c_S_IDLE:   if (bus.start)
                    w_state = (bus.mode == c_M_PUSH || bus.mode == c_M_PULL) ? c_S_STK : c_S_OPLO;
      c_S_OPLO:   begin
        if (r_mode == c_M_ABS || r_mode == c_M_ABS_IDX || r_mode == c_M_IND)
          w_state = c_S_OPHI;
        else if (r_mode == c_M_REL && bus.branch_take)
          w_state = c_S_BR;
        else
          w_state = c_S_IDLE;
      end
      c_S_OPHI:   begin
        if (r_mode == c_M_IND)
          w_state = c_S_IND_LO;
        else if (r_mode == c_M_ABS_IDX && w_fix)
          w_state = c_S_FIX;
        else
          w_state = c_S_IDLE;
      end
      c_S_IND_LO: w_state = c_S_IND_HI;
      c_S_BR:     w_state = w_same_page ? c_S_IDLE : c_S_BRFIX;
      default:    w_state = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_mode       = r_mode;
    w_idx        = r_idx;
    w_sp         = r_sp;
    w_lo         = r_lo;
    w_hi         = r_hi;
    w_lo2        = r_lo2;
    w_pc         = r_pc;
    w_tgt        = r_tgt;
    w_adr        = r_adr;
    w_pc_out     = r_pc_out;
    w_sp_out     = r_sp_out;
    w_busy       = r_busy;
    w_done       = 1'b0;
    w_pc_load    = 1'b0;
    w_sp_load    = 1'b0;
    w_mem_wr     = 1'b0;
    w_page_cross = 1'b0;
`ifdef CPU_ADDR_PAGE_FIX_EN
    w_carry      = r_carry;
`endif
    case (r_state)
      c_S_IDLE: begin
        if (bus.start) begin
          w_mode = bus.mode;
          w_idx  = bus.index;
          w_sp   = bus.sp_in;
          w_pc   = bus.pc_in;
          w_adr  = bus.pc_in;
          w_busy = 1'b1;
        end
      end
      c_S_OPLO: begin
        w_pc = w_pc_inc;
        case (r_mode)
          c_M_ABS, c_M_IND: begin
            w_lo  = bus.data_in;
            w_adr = w_pc_inc;
          end
          c_M_ABS_IDX: begin
            w_lo  = w_idx_lo;
            w_adr = w_pc_inc;
`ifdef CPU_ADDR_PAGE_FIX_EN
            w_carry = w_idx_sum[DATA_W];
`endif
          end
          c_M_ZP: begin
            w_adr  = {c_ZERO_D, bus.data_in};
            w_done = 1'b1;
            w_busy = 1'b0;
          end
          c_M_ZP_IDX: begin
            w_adr  = {c_ZERO_D, w_idx_lo};
            w_done = 1'b1;
            w_busy = 1'b0;
          end
          c_M_REL: begin
            if (bus.branch_take) begin
              w_tgt = w_br_tgt;
            end else begin
              w_pc_out  = w_pc_inc;
              w_pc_load = 1'b1;
              w_done    = 1'b1;
              w_busy    = 1'b0;
            end
          end
          default: begin
            w_done = 1'b1;
            w_busy = 1'b0;
          end
        endcase
      end
      c_S_OPHI: begin
        // Same address for final, dummy-read and pointer cases
        w_pc      = w_pc_inc;
        w_pc_out  = w_pc_inc;
        w_pc_load = 1'b1;
        w_hi      = bus.data_in;
        w_adr     = {bus.data_in, r_lo};
        if (r_mode == c_M_ABS_IDX && w_fix) begin
          w_page_cross = 1'b1;
        end else if (r_mode != c_M_IND) begin
          w_done = 1'b1;
          w_busy = 1'b0;
        end
      end
      c_S_FIX: begin
        w_adr  = {r_hi + c_ONE_D, r_lo};
        w_done = 1'b1;
        w_busy = 1'b0;
      end
      c_S_IND_LO: begin
        // Pointer increment stays inside its page, like the original 6502
        w_lo2 = bus.data_in;
        w_adr = {r_hi, r_lo + c_ONE_D};
      end
      c_S_IND_HI: begin
        w_pc_out  = {bus.data_in, r_lo2};
        w_adr     = {bus.data_in, r_lo2};
        w_pc_load = 1'b1;
        w_done    = 1'b1;
        w_busy    = 1'b0;
      end
      c_S_BR: begin
        if (w_same_page) begin
          w_pc_out  = r_tgt;
          w_adr     = r_tgt;
          w_pc_load = 1'b1;
          w_done    = 1'b1;
          w_busy    = 1'b0;
        end else begin
          w_page_cross = 1'b1;
        end
      end
      c_S_BRFIX: begin
        w_pc_out  = r_tgt;
        w_adr     = r_tgt;
        w_pc_load = 1'b1;
        w_done    = 1'b1;
        w_busy    = 1'b0;
      end
      c_S_STK: begin
        if (r_mode == c_M_PUSH) begin
          w_adr    = {STACK_HI, r_sp};
          w_mem_wr = 1'b1;
          w_sp_out = r_sp - c_ONE_D;
        end else begin
          w_adr    = {STACK_HI, r_sp + c_ONE_D};
          w_sp_out = r_sp + c_ONE_D;
        end
        w_sp_load = 1'b1;
        w_done    = 1'b1;
        w_busy    = 1'b0;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  assign bus.adr_out    = r_adr;
  assign bus.mem_wr     = r_mem_wr;
  assign bus.pc_out     = r_pc_out;
  assign bus.pc_load    = r_pc_load;
  assign bus.sp_out     = r_sp_out;
  assign bus.sp_load    = r_sp_load;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.page_cross = r_page_cross;

endmodule

`default_nettype wire
